// File: rtl/io_out_fifo.sv
// First-word-fall-through output queue between the datapath's strobed ioOut bus and a
// ready/valid consumer; a word strobed while the queue is full is dropped and latched in overflow.
module io_out_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [16:0]              ioOut,
    output logic [15:0]              outData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic wr_req;
    logic push;
    logic pop;

    assign outValid = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign overflow = ovf_q;
    assign outData  = outValid ? mem_q[rd_ptr_q] : 16'h0000;

    // A pop at full frees the slot the same edge, so the write still lands.
    assign wr_req = ioOut[16];
    assign pop    = outValid & outReady;
    assign push   = wr_req & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_req & ~push);
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ioOut[15:0];
        end
    end

endmodule

// File: tb/tb_io_out_fifo.sv
// Directed bench for io_out_fifo at DEPTH=4: reset, FWFT latency, overflow, full push+pop,
// wrap-around streaming, asynchronous mid-run reset and pops on an empty queue.
module tb_io_out_fifo;

    logic        clk;
    logic        reset;
    logic [16:0] ioOut;
    logic [15:0] outData;
    logic        outValid;
    logic        outReady;
    logic        full;
    logic        overflow;
    logic [2:0]  count;

    int vectors;
    int miscompares;

    io_out_fifo #(.DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .ioOut    (ioOut),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .full     (full),
        .overflow (overflow),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        ioOut       = '0;
        outReady    = 1'b0;

        #3;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(outValid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_data", 32'(outData), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // single word, zero-bubble latency
        ioOut = 17'h1_ABCD;
        tick();
        ioOut = '0;
        chk("single_valid", 32'(outValid), 1);
        chk("single_data", 32'(outData), 32'h0000ABCD);
        chk("single_count", 32'(count), 1);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk("single_pop_count", 32'(count), 0);
        chk("single_pop_data", 32'(outData), 0);
        chk("single_pop_valid", 32'(outValid), 0);

        // fill past capacity
        for (int i = 1; i <= 5; i++) begin
            ioOut = {1'b1, 16'(i)};
            tick();
            if (i == 4) begin
                chk("fill4_full", 32'(full), 1);
                chk("fill4_ovf", 32'(overflow), 0);
            end
        end
        ioOut = '0;
        chk("ovf_full", 32'(full), 1);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        outReady = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain", 32'(outData), 32'(i));
            tick();
        end
        outReady = 1'b0;
        chk("ovf_drain_empty", 32'(count), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        tick();
        chk("ovf_sticky2", 32'(overflow), 1);

        // async reset between edges, strobe waiting on the first edge after release
        #2 reset = 1'b1;
        #1;
        chk("rst2_ovf", 32'(overflow), 0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ioOut = {1'b1, 16'(i)};
            tick();
        end
        chk("full2_count", 32'(count), 4);
        ioOut    = 17'h1_00AA;
        outReady = 1'b1;
        tick();
        ioOut = '0;
        chk("pp_full_count", 32'(count), 4);
        chk("pp_full_full", 32'(full), 1);
        chk("pp_full_ovf", 32'(overflow), 0);
        chk("pp_drain0", 32'(outData), 2);
        tick();
        chk("pp_drain1", 32'(outData), 3);
        tick();
        chk("pp_drain2", 32'(outData), 4);
        tick();
        chk("pp_drain3", 32'(outData), 32'h00AA);
        tick();
        chk("pp_empty", 32'(count), 0);

        // streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            ioOut = {1'b1, 16'(16'h0010 + i)};
            tick();
            chk("wrap_data", 32'(outData), 32'(16'h0010 + i));
            chk("wrap_count", 32'(count), 1);
        end
        ioOut = '0;
        tick();
        chk("wrap_empty", 32'(count), 0);
        outReady = 1'b0;

        // build count=3 with overflow set, then reset mid-cycle
        for (int i = 0; i < 5; i++) begin
            ioOut = {1'b1, 16'(16'h0021 + i)};
            tick();
        end
        ioOut    = '0;
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk("mid_count", 32'(count), 3);
        chk("mid_ovf", 32'(overflow), 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(outValid), 0);
        chk("mid_rst_full", 32'(full), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_data", 32'(outData), 0);
        #1 reset = 1'b0;
        ioOut = 17'h1_0BEE;
        tick();
        ioOut = 17'h1_0C01;
        tick();
        ioOut = '0;
        chk("mid_head", 32'(outData), 32'h0BEE);
        outReady = 1'b1;
        tick();
        chk("mid_second", 32'(outData), 32'h0C01);
        tick();
        chk("mid_empty", 32'(count), 0);

        // pops on an empty queue are ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("epop_count", 32'(count), 0);
        end
        ioOut = 17'h1_5678;
        tick();
        ioOut    = '0;
        outReady = 1'b0;
        chk("push_empty_rdy_count", 32'(count), 1);
        chk("push_empty_rdy_data", 32'(outData), 32'h5678);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        ioOut    = 17'h1_1234;
        tick();
        ioOut = '0;
        chk("epop_after_data", 32'(outData), 32'h1234);
        chk("epop_after_count", 32'(count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
